morse_player: RTL and testbench
===============================

# morse_player

Reads 2-bit Morse symbols out of the symbol FIFO and plays them back as a timed on/off `tone` signal (LED/buzzer drive). It is the read-side consumer of the FIFO that the keyer/decoder front end fills: it drives the FIFO `re`, samples its registered `data_out`, and converts each symbol into mark and space durations measured in Morse time units. Playback starts on a `start` pulse and runs until the FIFO is empty or `abort` is asserted.

## Interface
- `CLKS_PER_UNIT`, 12_500_000, clock cycles per Morse time unit (0.25 s at 50 MHz); must be ≥ 2.
- `DOT_UNITS`, 1, mark length of a dot.
- `DASH_UNITS`, 3, mark length of a dash.
- `SYM_GAP_UNITS`, 1, space after every dot/dash.
- `LETTER_GAP_UNITS`, 2, extra space for a letter-gap symbol (total 3 after the preceding symbol gap).
- `WORD_GAP_UNITS`, 6, extra space for a word-gap symbol (total 7).
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins playback from IDLE, ignored otherwise.
- `abort` in 1: level; forces return to IDLE at the next clock edge.
- `fifo_empty` in 1: FIFO `empty`.
- `fifo_data` in 2: FIFO `data_out`, valid the cycle after a read strobe.
- `fifo_re` out 1: FIFO read strobe, one cycle per symbol.
- `tone` out 1: 1 = mark (key down).
- `busy` out 1: high in every state except IDLE; upstream must hold FIFO `we`/`del` off while high.
- `done` out 1: one-cycle pulse when playback ends because the FIFO ran empty.

## Operation
- Symbol encoding: 2'b00 dot, 2'b01 dash, 2'b10 letter gap, 2'b11 word gap.
- States: IDLE, REQ, LATCH, MARK, SPACE, FINISH.
- IDLE: all outputs 0. `start` → REQ.
- REQ: if `fifo_empty` → FINISH; else assert `fifo_re` for this cycle only → LATCH.
- LATCH: register `fifo_data`. Dot/dash → MARK with unit count DOT_UNITS/DASH_UNITS. Letter/word gap → SPACE with LETTER_GAP_UNITS/WORD_GAP_UNITS.
- MARK: `tone`=1 until the unit count expires → SPACE with SYM_GAP_UNITS.
- SPACE: `tone`=0 until the count expires → REQ.
- FINISH: `done`=1 for one cycle → IDLE.
- `abort` has priority over every transition. Next edge → IDLE, `tone`=0, no `done`. Any in-flight symbol is discarded.
- `fifo_re` is never asserted while `fifo_empty`=1 and never on two consecutive cycles.
- Unit timing: the prescaler counts 0..CLKS_PER_UNIT-1 and emits `unit_tick` at the top. It is cleared on entry to MARK and SPACE, so every interval is exactly N·CLKS_PER_UNIT cycles. The unit counter is 3 bits, which limits every *_UNITS parameter to 1..7. The prescaler width is $clog2(CLKS_PER_UNIT).
- A gap symbol with value 0 units is not allowed.

## Timing
- Reset (rst=0, asynchronous): state IDLE, counters 0, `tone`/`fifo_re`/`busy`/`done` = 0. Reset mid-symbol is applied immediately, without waiting for a clock edge.
- `start` at edge k: REQ in cycle k+1 (`busy`=1, `fifo_re`=1 if non-empty), LATCH in k+2, MARK/SPACE from k+3.
- Dot: `tone` high exactly DOT_UNITS·CLKS_PER_UNIT cycles, then low SYM_GAP_UNITS·CLKS_PER_UNIT cycles.
- Per-symbol overhead: 2 cycles (REQ + LATCH) of `tone`=0, added to each SPACE.
- Empty FIFO at `start`: REQ → FINISH → IDLE. `done` is high in cycle k+2 and `busy` falls in k+3.
- `start` while busy: ignored.
- `start` and `abort` in the same cycle from IDLE: stay in IDLE.

## Structure
- Package `morse_pkg`: symbol enum (`SYM_DOT`, `SYM_DASH`, `SYM_LGAP`, `SYM_WGAP`) and the player state enum. Both are shared with the front-end encoder.
- Sub-module `unit_timer`: prescaler plus 3-bit down-counter.
  - Inputs: `load`, `units`.
  - Output: `expired`.
  - Uses the same `clk`/`rst`.
- The top level holds the FSM and the symbol register.

## Test plan
(Run with CLKS_PER_UNIT=4 and the other parameters at default.)
- Reset mid-MARK: drop `rst` asynchronously. `tone`/`busy` go to 0 before the next edge, and the state is IDLE after release.
- FIFO preloaded with dot, dash → `fifo_re` pulses twice, non-consecutive. `tone` is high 4 cycles, low 6 (4 + 2 overhead), high 12, low 4. `done` follows 2 cycles after the last SPACE.
- FIFO preloaded with dot, letter gap, dot → first low interval 6 cycles, second 10 cycles (8 + 2).
- Empty FIFO, `start` → `fifo_re` never asserted. `done`=1 exactly 2 cycles after `start`, `tone` stays 0.
- `abort` pulsed 5 cycles into a dash (word-gap queued behind it) → `tone`=0 and IDLE next edge. No `done`. The FIFO still holds the word-gap symbol.
- `start` re-pulsed during playback → no effect on the `tone` waveform or on the `fifo_re` count.

Source files
------------

// File: rtl/morse_player_pkg.sv
// ============================================================================
// Module : morse_pkg
// Brief  : Symbol and player-state enums shared by the Morse encoder and player.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package morse_pkg;

    typedef enum logic [1:0] {
        SYM_DOT  = 2'b00,
        SYM_DASH = 2'b01,
        SYM_LGAP = 2'b10,
        SYM_WGAP = 2'b11
    } sym_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_LATCH  = 3'd2,
        ST_MARK   = 3'd3,
        ST_SPACE  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    localparam int c_UNIT_CNT_W = 3;

endpackage

`default_nettype wire

// File: rtl/morse_player_if.sv
// ============================================================================
// Module : morse_player_if
// Brief  : Control, FIFO read side and tone output bundle of the Morse player.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface morse_player_if;
    logic       start;
    logic       abort;
    logic       fifo_empty;
    logic [1:0] fifo_data;
    logic       fifo_re;
    logic       tone;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, fifo_empty, fifo_data,
        input  fifo_re, tone, busy, done
    );

    modport slave (
        input  start, abort, fifo_empty, fifo_data,
        output fifo_re, tone, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/morse_player_unit_timer.sv
// ============================================================================
// Module : unit_timer
// Brief  : Prescaler to one Morse unit plus a 3-bit unit down-counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unit_timer
    import morse_pkg::*;
#(
    parameter int CLKS_PER_UNIT = 12_500_000
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    i_load,
    input  wire logic [c_UNIT_CNT_W-1:0] i_units,
    output logic                         o_expired
);

    localparam int                 c_PRE_W   = $clog2(CLKS_PER_UNIT);
    localparam logic [c_PRE_W-1:0] c_PRE_TOP = c_PRE_W'(CLKS_PER_UNIT - 1);

    logic [c_PRE_W-1:0]      r_pre;
    logic [c_UNIT_CNT_W-1:0] r_cnt;
    logic                    w_tick;

    assign w_tick    = (r_pre == c_PRE_TOP);
    // Fires on the last cycle of the final unit so the FSM leaves on that edge.
    assign o_expired = w_tick && (r_cnt == c_UNIT_CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_pre <= '0;
            r_cnt <= i_units;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + c_PRE_W'(1);
            if (w_tick && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_UNIT_CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/morse_player.sv
// ============================================================================
// Module : morse_player
// Brief  : Plays Morse symbols from the symbol FIFO as a timed on/off tone.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_player
    import morse_pkg::*;
#(
    parameter int CLKS_PER_UNIT    = 12_500_000,
    parameter int DOT_UNITS        = 1,
    parameter int DASH_UNITS       = 3,
    parameter int SYM_GAP_UNITS    = 1,
    parameter int LETTER_GAP_UNITS = 2,
    parameter int WORD_GAP_UNITS   = 6
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    morse_player_if.slave  bus
);

    localparam logic [c_UNIT_CNT_W-1:0] c_DOT  = c_UNIT_CNT_W'(DOT_UNITS);
    localparam logic [c_UNIT_CNT_W-1:0] c_DASH = c_UNIT_CNT_W'(DASH_UNITS);
    localparam logic [c_UNIT_CNT_W-1:0] c_SGAP = c_UNIT_CNT_W'(SYM_GAP_UNITS);
    localparam logic [c_UNIT_CNT_W-1:0] c_LGAP = c_UNIT_CNT_W'(LETTER_GAP_UNITS);
    localparam logic [c_UNIT_CNT_W-1:0] c_WGAP = c_UNIT_CNT_W'(WORD_GAP_UNITS);

    state_t                  r_state;
    state_t                  w_next;
    sym_t                    r_sym;
    logic                    w_load;
    logic [c_UNIT_CNT_W-1:0] w_units;
    logic                    w_expired;
    logic                    w_re;

    unit_timer #(
        .CLKS_PER_UNIT (CLKS_PER_UNIT)
    ) u_unit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_units   (w_units),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sym   <= SYM_DOT;
        end else begin
            r_state <= w_next;
            if (r_state == ST_LATCH) begin
                r_sym <= sym_t'(bus.fifo_data);
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_units = c_SGAP;
        w_re    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_REQ;
            end
            ST_REQ: begin
                if (bus.fifo_empty) begin
                    w_next = ST_FINISH;
                end else begin
                    w_re   = 1'b1;
                    w_next = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // fifo_data is the registered FIFO output, valid this cycle only.
                w_load = 1'b1;
                case (sym_t'(bus.fifo_data))
                    SYM_DOT:  begin w_units = c_DOT;  w_next = ST_MARK;  end
                    SYM_DASH: begin w_units = c_DASH; w_next = ST_MARK;  end
                    SYM_LGAP: begin w_units = c_LGAP; w_next = ST_SPACE; end
                    SYM_WGAP: begin w_units = c_WGAP; w_next = ST_SPACE; end
                    default:  begin w_units = c_SGAP; w_next = ST_SPACE; end
                endcase
            end
            ST_MARK: begin
                if (w_expired) begin
                    w_load  = 1'b1;
                    w_units = c_SGAP;
                    w_next  = ST_SPACE;
                end
            end
            ST_SPACE: begin
                if (w_expired) w_next = ST_REQ;
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        // Abort wins over everything; no read so the queued symbol survives.
        if (bus.abort) begin
            w_next = ST_IDLE;
            w_load = 1'b0;
            w_re   = 1'b0;
        end
    end

    assign bus.fifo_re = w_re;
    assign bus.tone    = (r_state == ST_MARK) && ((r_sym == SYM_DOT) || (r_sym == SYM_DASH));
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = (r_state == ST_FINISH);

endmodule

`default_nettype wire

// File: tb/tb_morse_player.sv
// ============================================================================
// Module : tb_morse_player
// Brief  : Directed self-checking bench for morse_player with CLKS_PER_UNIT=4.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morse_player;
    import morse_pkg::*;

    logic clk;
    logic rst_n;

    morse_player_if bus ();

    morse_player #(
        .CLKS_PER_UNIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Symbol FIFO model with a registered data_out.
    logic [1:0] mem [0:15];
    int         rd_ptr;
    int         wr_ptr;

    initial rd_ptr = 0;
    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.fifo_re) begin
            bus.fifo_data <= mem[rd_ptr % 16];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    int n_checks;
    int n_pass;

    bit tone_tr [0:511];
    bit re_tr   [0:511];
    bit done_tr [0:511];
    bit busy_tr [0:511];
    int n_cap;

    task automatic load(input int n, input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2);
        logic [1:0] s [0:2];
        s[0] = s0; s[1] = s1; s[2] = s2;
        for (int k = 0; k < n; k++) mem[(rd_ptr + k) % 16] = s[k];
        wr_ptr = rd_ptr + n;
    endtask

    // Records one sample per cycle after a start pulse until busy drops.
    task automatic capture(input int period, output bit timeout);
        @(negedge clk);
        bus.start = 1'b1;
        n_cap   = 0;
        timeout = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.start  = (period > 0) && ((i % period) == period - 1);
            tone_tr[i] = bus.tone;
            re_tr[i]   = bus.fifo_re;
            done_tr[i] = bus.done;
            busy_tr[i] = bus.busy;
            n_cap      = i + 1;
            if (!bus.busy) begin
                timeout = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    function automatic int run_len(input int from, input bit v);
        int n = 0;
        while ((from + n < n_cap) && (tone_tr[from + n] == v)) n++;
        return n;
    endfunction

    function automatic int count_re();
        int n = 0;
        for (int i = 0; i < n_cap; i++) if (re_tr[i]) n++;
        return n;
    endfunction

    function automatic int count_done();
        int n = 0;
        for (int i = 0; i < n_cap; i++) if (done_tr[i]) n++;
        return n;
    endfunction

    function automatic int count_back_to_back_re();
        int n = 0;
        for (int i = 1; i < n_cap; i++) if (re_tr[i] && re_tr[i-1]) n++;
        return n;
    endfunction

    function automatic int count_tone();
        int n = 0;
        for (int i = 0; i < n_cap; i++) if (tone_tr[i]) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({bus.tone, bus.busy, bus.done, bus.fifo_re} !== 4'b0000)
            $display("FAIL reset_outputs: got %b required 0000", {bus.tone, bus.busy, bus.done, bus.fifo_re});
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_idle_busy: got %b required 0", bus.busy);
        else n_pass++;
    endtask

    // Shared expectations for the dot,dash stream; period=0 means no extra starts.
    task automatic test_dot_dash(input string tag, input int period);
        bit to;
        load(2, SYM_DOT, SYM_DASH, SYM_DOT);
        capture(period, to);
        n_checks++; if (to !== 1'b0 || n_cap != 31) $display("FAIL %s_length: timeout %0d samples %0d required 0/31", tag, to, n_cap);
        else n_pass++;
        n_checks++; if (count_re() != 2 || !re_tr[0] || !re_tr[10])
            $display("FAIL %s_re: count %0d re0 %0d re10 %0d required 2/1/1", tag, count_re(), re_tr[0], re_tr[10]);
        else n_pass++;
        n_checks++; if (count_back_to_back_re() != 0) $display("FAIL %s_re_consecutive: got %0d required 0", tag, count_back_to_back_re());
        else n_pass++;
        n_checks++; if (tone_tr[1] !== 1'b0 || run_len(2, 1'b1) != 4) $display("FAIL %s_dot_mark: got %0d required 4", tag, run_len(2, 1'b1));
        else n_pass++;
        n_checks++; if (run_len(6, 1'b0) != 6) $display("FAIL %s_dot_space: got %0d required 6", tag, run_len(6, 1'b0));
        else n_pass++;
        n_checks++; if (run_len(12, 1'b1) != 12) $display("FAIL %s_dash_mark: got %0d required 12", tag, run_len(12, 1'b1));
        else n_pass++;
        n_checks++; if (count_done() != 1 || done_tr[29] !== 1'b1 || tone_tr[29] !== 1'b0)
            $display("FAIL %s_done: count %0d done29 %0d required 1/1", tag, count_done(), done_tr[29]);
        else n_pass++;
    endtask

    task automatic test_letter_gap();
        bit to;
        load(3, SYM_DOT, SYM_LGAP, SYM_DOT);
        capture(0, to);
        n_checks++; if (to !== 1'b0 || n_cap != 33) $display("FAIL lgap_length: timeout %0d samples %0d required 0/33", to, n_cap);
        else n_pass++;
        n_checks++; if (run_len(2, 1'b1) != 4) $display("FAIL lgap_first_mark: got %0d required 4", run_len(2, 1'b1));
        else n_pass++;
        // 6 after the dot plus 10 for the letter gap, contiguous on the line.
        n_checks++; if (run_len(6, 1'b0) != 16) $display("FAIL lgap_space: got %0d required 16", run_len(6, 1'b0));
        else n_pass++;
        n_checks++; if (run_len(22, 1'b1) != 4) $display("FAIL lgap_second_mark: got %0d required 4", run_len(22, 1'b1));
        else n_pass++;
        n_checks++; if (count_re() != 3 || done_tr[31] !== 1'b1)
            $display("FAIL lgap_re_done: re %0d done31 %0d required 3/1", count_re(), done_tr[31]);
        else n_pass++;
    endtask

    task automatic test_empty();
        bit to;
        load(0, SYM_DOT, SYM_DOT, SYM_DOT);
        capture(0, to);
        n_checks++; if (to !== 1'b0 || n_cap != 3 || busy_tr[0] !== 1'b1)
            $display("FAIL empty_length: timeout %0d samples %0d busy0 %0d required 0/3/1", to, n_cap, busy_tr[0]);
        else n_pass++;
        n_checks++; if (count_re() != 0) $display("FAIL empty_re: got %0d required 0", count_re());
        else n_pass++;
        n_checks++; if (done_tr[1] !== 1'b1 || count_done() != 1) $display("FAIL empty_done: done1 %0d count %0d required 1/1", done_tr[1], count_done());
        else n_pass++;
        n_checks++; if (count_tone() != 0) $display("FAIL empty_tone: got %0d high cycles required 0", count_tone());
        else n_pass++;
    endtask

    task automatic test_abort();
        int n_re;
        int n_done;
        load(2, SYM_DASH, SYM_WGAP, SYM_DOT);
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        n_checks++; if (bus.tone !== 1'b1) $display("FAIL abort_in_dash: tone %b required 1", bus.tone);
        else n_pass++;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_checks++; if (bus.tone !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL abort_idle: tone %b busy %b done %b required 000", bus.tone, bus.busy, bus.done);
        else n_pass++;
        n_re = 0; n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.fifo_re) n_re++;
            if (bus.done) n_done++;
        end
        n_checks++; if (n_re != 0 || n_done != 0) $display("FAIL abort_quiet: re %0d done %0d required 0/0", n_re, n_done);
        else n_pass++;
        n_checks++; if ((wr_ptr - rd_ptr) != 1 || mem[rd_ptr % 16] !== SYM_WGAP)
            $display("FAIL abort_fifo_left: entries %0d head %b required 1/11", wr_ptr - rd_ptr, mem[rd_ptr % 16]);
        else n_pass++;
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.fifo_re !== 1'b0)
            $display("FAIL start_with_abort: busy %b re %b required 0/0", bus.busy, bus.fifo_re);
        else n_pass++;
    endtask

    task automatic test_reset_mid_mark();
        load(1, SYM_DASH, SYM_DOT, SYM_DOT);
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        n_checks++; if (bus.tone !== 1'b1) $display("FAIL rst_pre_mark: tone %b required 1", bus.tone);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.tone !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL rst_async: tone %b busy %b required 0/0", bus.tone, bus.busy);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (dut.r_state !== ST_IDLE || bus.busy !== 1'b0 || bus.tone !== 1'b0)
            $display("FAIL rst_release_idle: state %0d busy %b tone %b required 0/0/0", dut.r_state, bus.busy, bus.tone);
        else n_pass++;
        load(0, SYM_DOT, SYM_DOT, SYM_DOT);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        wr_ptr    = 0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        test_reset();
        test_dot_dash("dotdash", 0);
        test_letter_gap();
        test_empty();
        test_abort();
        test_dot_dash("restart", 3);
        test_reset_mid_mark();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
